// File: rtl/sd_arith_pkg.sv
// sd_arith_pkg: shared state encodings and byte width for the serial arithmetic blocks
package sd_arith_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/sklansky_8.sv
// sklansky_8: 8-bit Sklansky parallel-prefix adder with carry-in folded into bit 0
module sklansky_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);
  logic [7:0] p, g, pp;
  assign p = a ^ b;
  always_comb begin
    g = a & b;
    g[0] = g[0] | (p[0] & cin);
    pp = p;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 8; i++)
        if (i[k]) begin
          g[i] = g[i] | (pp[i] & g[((i >> k) << k) - 1]);
          pp[i] = pp[i] & pp[((i >> k) << k) - 1];
        end
  end
  assign s = p ^ {g[6:0], cin};
  assign cout = g[7];
endmodule

// File: rtl/byte_serial_adder.sv
// byte_serial_adder: wide add/subtract streamed one byte per cycle through a single prefix adder
module byte_serial_adder
  import sd_arith_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  input  logic                cin,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] sum,
  output logic                cout,
  output logic                ovf
);
  localparam int W  = BYTE_W * NBYTES;
  localparam int IW = $clog2(NBYTES);
  state_t state, nxt;
  logic [IW-1:0] idx;
  logic [W-1:0] sa, sb, res;
  logic carry, sign_a, sign_b, c8;
  logic [BYTE_W-1:0] s8;
  sklansky_8 u_add (
    .a   (sa[BYTE_W-1:0]),
    .b   (sb[BYTE_W-1:0]),
    .cin (carry),
    .s   (s8),
    .cout(c8)
  );
  always_comb begin
    nxt = (state == ST_IDLE) ? (in_valid ? ST_RUN : ST_IDLE) :
          (state == ST_RUN)  ? ((idx == IW'(NBYTES - 1)) ? ST_DONE : ST_RUN) :
                               (out_ready ? ST_IDLE : ST_DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      idx    <= '0;
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      carry  <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
    end else begin
      state <= nxt;
      if (state == ST_IDLE && in_valid) begin
        sa     <= a;
        sb     <= b ^ {W{sub}};
        carry  <= sub | cin;
        sign_a <= a[W-1];
        sign_b <= b[W-1] ^ sub;
        idx    <= '0;
      end else if (state == ST_RUN) begin
        res   <= {s8, res[W-1:BYTE_W]};
        sa    <= sa >> BYTE_W;
        sb    <= sb >> BYTE_W;
        carry <= c8;
        idx   <= idx + IW'(1);
      end
    end
  end
  assign in_ready  = state == ST_IDLE;
  assign out_valid = state == ST_DONE;
  assign sum       = res;
  assign cout      = carry;
  assign ovf       = (sign_a == sign_b) && (res[W-1] != sign_a);
endmodule

// File: tb/tb_byte_serial_adder.sv
// tb_byte_serial_adder: table, corner-case and random scoreboard checks of byte_serial_adder
module tb_byte_serial_adder;
  localparam int NB = 4;
  localparam int W  = 8 * NB;
  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } res_t;
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    res_t         e;
  } vec_t;
  logic clk = 0, rst = 1, in_valid = 0, cin = 0, sub = 0, out_ready = 0;
  logic in_ready, out_valid, cout, ovf;
  logic [W-1:0] a = '0, b = '0, sum;
  res_t q[$];
  int vectors = 0, miscompares = 0, cyc = 0, acc_cyc = 0, waited;
  logic prev_valid = 0, hs_prev = 0, rand_rdy = 0;
  vec_t tbl[9];
  byte_serial_adder #(.NBYTES(NB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  function automatic res_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input logic ts);
    res_t r;
    logic [W-1:0] eb;
    logic [W:0] t;
    eb = ts ? ~tb_ : tb_;
    t = {1'b0, ta} + {1'b0, eb} + {{W{1'b0}}, ts ? 1'b1 : tc};
    r.s = t[W-1:0];
    r.c = t[W];
    r.o = (ta[W-1] == eb[W-1]) && (r.s[W-1] != ta[W-1]);
    return r;
  endfunction
  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      q.delete();
      prev_valid <= 0;
      hs_prev <= 0;
    end else begin
      if (hs_prev) chk("in_ready_after_handshake", in_ready, 1);
      if (out_valid && !prev_valid) chk("latency", cyc - acc_cyc, NB + 1);
      if (in_valid && in_ready) acc_cyc <= cyc;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          e = q.pop_front();
          chk("sum", sum, e.s);
          chk("cout", cout, e.c);
          chk("ovf", ovf, e.o);
        end
      end
      prev_valid <= out_valid;
      hs_prev <= out_valid && out_ready;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input logic ts, input res_t e, output int w);
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1; w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      tick();
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    else q.push_back(e);
    tick();
    in_valid = 0; a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
  endtask
  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 500) begin
      tick();
      n++;
    end
    chk("drain_empty", q.size(), 0);
  endtask
  initial begin
    logic [W-1:0] s0, ra, rb;
    logic c0, o0, rc, rs;
    tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 0, 0, '{32'h0000_0000, 1, 0}};
    tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 0, 0, '{32'h8000_0000, 0, 1}};
    tbl[2] = '{32'h1234_5678, 32'h1111_1111, 1, 0, '{32'h2345_678A, 0, 0}};
    tbl[3] = '{32'h0000_0005, 32'h0000_0007, 1, 1, '{32'hFFFF_FFFE, 0, 0}};
    tbl[4] = '{32'h8000_0000, 32'h0000_0001, 0, 1, '{32'h7FFF_FFFF, 1, 1}};
    tbl[5] = '{32'h00FF_FFFF, 32'h0000_0000, 1, 0, '{32'h0100_0000, 0, 0}};
    tbl[6] = '{32'h0000_0000, 32'h0000_0000, 0, 1, '{32'h0000_0000, 1, 0}};
    tbl[7] = '{32'h8000_0000, 32'h8000_0000, 0, 0, '{32'h0000_0000, 1, 1}};
    tbl[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, '{32'hFFFF_FFFF, 1, 0}};
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    rst = 0;
    out_ready = 1;
    tick();
    for (int i = 0; i < 9; i++) send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, tbl[i].e, waited);
    drain();
    out_ready = 0;
    send(32'h0000_1234, 32'h0000_4321, 0, 0, '{32'h0000_5555, 0, 0}, waited);
    in_valid = 1; a = 32'hDEAD_BEEF; b = 32'h1; sub = 1;
    tick();
    in_valid = 0;
    for (int n = 0; n < 20 && !out_valid; n++) tick();
    chk("bp_valid_seen", out_valid, 1);
    s0 = sum; c0 = cout; o0 = ovf;
    for (int n = 0; n < 10; n++) begin
      in_valid = n[0]; a = $urandom; b = $urandom;
      tick();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_sum", sum, s0);
      chk("bp_cout", cout, c0);
      chk("bp_ovf", ovf, o0);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 0;
    out_ready = 1;
    send(32'h0000_000A, 32'h0000_0003, 0, 1, '{32'h0000_0007, 1, 0}, waited);
    chk("next_accept_wait", waited, 1);
    drain();
    send(32'h0102_0304, 32'h0506_0708, 0, 0, '{32'h0608_0A0C, 0, 0}, waited);
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    for (int n = 0; n < 8; n++) begin
      tick();
      chk("post_rst_no_valid", out_valid, 0);
    end
    send(32'h1, 32'h1, 0, 0, '{32'h2, 0, 0}, waited);
    drain();
    rand_rdy = 1;
    for (int n = 0; n < 40; n++) begin
      if (n % 8 == 0) begin
        ra = 32'hFFFF_FFFF >> (8 * $urandom_range(1, 3)); rb = '0; rc = 1; rs = 0;
      end else begin
        ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
      end
      send(ra, rb, rc, rs, model(ra, rb, rc, rs), waited);
    end
    drain();
    rand_rdy = 0;
    out_ready = 1;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
